spike_rate_monitor: RTL
=======================

Name: spike_rate_monitor

Overview:
- Sits directly downstream of the LIF neuron and consumes its `spike` output.
- Counts spike rising edges over a programmable window and reports the count once per window.
- Also measures the inter-spike interval (ISI) between consecutive spikes.
- Gives the chip a readable firing-rate and timing readout instead of a raw spike line.

Parameters:
- WIN_W, 8, width of window-length input and window counter.
- CNT_W, 8, width of the per-window spike count (saturating).
- ISI_W, 8, width of the ISI measurement (saturating).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = measure; 0 = idle, internal counters cleared.
- spike_in  in  1  spike line from LIF neuron; pulse or level.
- window_len  in  WIN_W  window length in cycles; sampled at each window start; 0 treated as 1.
- rate_count  out  CNT_W  spike-edge count of the last completed window; held until next window ends.
- rate_valid  out  1  one-cycle pulse when rate_count updates.
- last_isi  out  ISI_W  cycles between the two most recent spike edges; held.
- isi_valid  out  1  one-cycle pulse when last_isi updates.
- win_busy  out  1  1 while a window is in progress (state RUN).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0; state = IDLE.
  - Internal spike_q, win_cnt, acc, isi_cnt and have_prev are all cleared.
  - Reset overrides everything, including a window in progress.
- Edge detect:
  - spike_q registers spike_in every cycle.
  - edge = spike_in & ~spike_q.
  - A level held high for many cycles counts once.
  - spike_q is also updated in IDLE, so a line already high when enable rises does not produce an edge.
- States:
  - IDLE: win_busy=0; acc, win_cnt, isi_cnt and have_prev cleared every cycle. rate_count and last_isi hold their values. If enable=1, go to RUN and load win_cnt = max(window_len,1)-1.
  - RUN: win_busy=1. Each cycle, acc += edge, saturating at 2^CNT_W-1.
  - RUN, win_cnt != 0: decrement win_cnt.
  - RUN, win_cnt == 0 (last cycle of window):
    - rate_count <= saturate(acc + edge); rate_valid <= 1 on the next cycle.
    - acc <= 0.
    - If enable=1, reload win_cnt from window_len; windows are back-to-back with no gap cycle. If enable=0, go to IDLE.
  - RUN with enable=0 before the last cycle: abort to IDLE next cycle. No rate_valid; partial count discarded.
- Window length: exactly N = max(window_len,1) cycles; edges in all N cycles are counted.
- ISI (RUN only):
  - isi_cnt increments every cycle, saturating at 2^ISI_W-1.
  - On an edge with have_prev=1: last_isi <= isi_cnt+1 (saturating); isi_valid pulses next cycle; isi_cnt <= 0.
  - On an edge with have_prev=0: set have_prev and clear isi_cnt; no isi_valid.
  - Edges at cycles t and t+k give last_isi = k.
  - ISI tracking continues across window boundaries. Leaving RUN clears have_prev.
- Latency: outputs are registered and visible one clk after the triggering cycle.
- Simultaneous events:
  - An edge on a window's last cycle counts in that window.
  - rate_valid and isi_valid may assert in the same cycle.
- Saturation: counters hold at max and never wrap.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with spike_in toggling → all outputs 0, win_busy=0; after rst=0 with enable=0, outputs stay 0.
- Basic rate: window_len=10, enable=1, single-cycle spikes at cycles 2, 5, 9 of the window → one rate_valid pulse after cycle 10 with rate_count=3. The next window with no spikes → rate_count=0.
- Edge-on-boundary and level: spike on the last window cycle is counted in that window. spike_in held high for 4 cycles → counts 1.
- ISI: pulses 7 cycles apart → first pulse gives no isi_valid; second gives isi_valid with last_isi=7. Pulses 300 cycles apart with ISI_W=8 → last_isi=255.
- Saturation and zero length: CNT_W=8, window_len=0 (→1) → every cycle yields rate_valid. Alternating spike_in every cycle with window_len=255 → rate_count=128 (exact, no wrap); with 600 edges forced via a wider window, rate_count=255.
- Abort/reset mid-window: drop enable at cycle 4 of 10 → no rate_valid, win_busy=0 next cycle, rate_count keeps the old value. Assert rst mid-window → all outputs 0 next cycle.

Source files
------------

// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts spike edges per programmable window
// and measures the inter-spike interval between consecutive edges.
module spike_rate_monitor #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8,
    parameter int ISI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_count,
    output logic             rate_valid,
    output logic [ISI_W-1:0] last_isi,
    output logic             isi_valid,
    output logic             win_busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    state_t           state_q, state_d;
    logic             spike_q;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             have_prev_q, have_prev_d;
    logic [CNT_W-1:0] rate_count_q, rate_count_d;
    logic             rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0] last_isi_q, last_isi_d;
    logic             isi_valid_q, isi_valid_d;

    logic             edge_w;
    logic [WIN_W-1:0] win_load;
    logic [CNT_W-1:0] acc_sat;
    logic [ISI_W-1:0] isi_inc;

    // Rising edge of the spike line; a held level counts once.
    assign edge_w   = spike_in & ~spike_q;
    // A zero window length behaves as a one-cycle window.
    assign win_load = (window_len == '0) ? '0 : window_len - 1'b1;
    assign acc_sat  = (acc_q == CNT_MAX) ? CNT_MAX
                    : acc_q + {{(CNT_W-1){1'b0}}, edge_w};
    assign isi_inc  = (isi_cnt_q == ISI_MAX) ? ISI_MAX
                    : isi_cnt_q + 1'b1;

    // Next-state and measurement logic for the window FSM.
    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        isi_cnt_d    = isi_cnt_q;
        have_prev_d  = have_prev_q;
        rate_count_d = rate_count_q;
        rate_valid_d = 1'b0;
        last_isi_d   = last_isi_q;
        isi_valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                acc_d       = '0;
                win_cnt_d   = '0;
                isi_cnt_d   = '0;
                have_prev_d = 1'b0;
                if (enable) begin
                    state_d   = RUN;
                    win_cnt_d = win_load;
                end
            end
            RUN: begin
                acc_d     = acc_sat;
                isi_cnt_d = isi_inc;
                if (edge_w) begin
                    isi_cnt_d = '0;
                    if (have_prev_q) begin
                        last_isi_d  = isi_inc;
                        isi_valid_d = 1'b1;
                    end else begin
                        have_prev_d = 1'b1;
                    end
                end
                if (win_cnt_q == '0) begin
                    rate_count_d = acc_sat;
                    rate_valid_d = 1'b1;
                    acc_d        = '0;
                    if (enable) begin
                        win_cnt_d = win_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            spike_q      <= 1'b0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            isi_cnt_q    <= '0;
            have_prev_q  <= 1'b0;
            rate_count_q <= '0;
            rate_valid_q <= 1'b0;
            last_isi_q   <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike_in;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            isi_cnt_q    <= isi_cnt_d;
            have_prev_q  <= have_prev_d;
            rate_count_q <= rate_count_d;
            rate_valid_q <= rate_valid_d;
            last_isi_q   <= last_isi_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    assign rate_count = rate_count_q;
    assign rate_valid = rate_valid_q;
    assign last_isi   = last_isi_q;
    assign isi_valid  = isi_valid_q;
    assign win_busy   = (state_q == RUN);

endmodule
